// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU round-robin arbiter.
// Opcode encoding matches the shared ALU instance.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;

  localparam int RES_W = 16;
  localparam int OPD_W = 8;

  function automatic logic is_nop(
    input logic [2:0] op
  );
    return op == OP_NOP;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search from ptr upward modulo N.
// Produces a one-hot grant and its index; zero grant when idle.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grants.
// Owns start/done handshaking, local NOP completion and the wait timeout.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OPD_W-1:0]   req_a,
  input  logic [NUM_REQ*OPD_W-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]       req_opcode,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [RES_W-1:0]           rsp_result,
  output logic                       rsp_err,
  output logic [OPD_W-1:0]           alu_a,
  output logic [OPD_W-1:0]           alu_b,
  output logic [2:0]                 alu_opcode,
  output logic                       alu_start,
  input  logic [RES_W-1:0]           alu_result,
  input  logic                       alu_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0]     wait_cnt;
  logic              grant_fire;
  logic              timed_out;
  logic [OPD_W-1:0]  sel_a;
  logic [OPD_W-1:0]  sel_b;
  logic [2:0]        sel_op;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_a      = req_a[grant_id*OPD_W +: OPD_W];
  assign sel_b      = req_b[grant_id*OPD_W +: OPD_W];
  assign sel_op     = req_opcode[grant_id*3 +: 3];
  assign grant_fire = (state == IDLE) && (|req_valid);
  assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (grant_fire)
               state_nxt = is_nop(sel_op) ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (alu_done || timed_out)
               state_nxt = RESP;
      RESP:  if (rsp_ready)
               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so it reads zero while reset is held
  always_comb begin
    req_ready = '0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE:  req_ready = rst ? '0 : grant;
      ISSUE: alu_start = 1'b1;
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
    end else begin
      if (grant_fire) begin
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        alu_opcode <= sel_op;
        rsp_id     <= grant_id;
        rsp_result <= '0;
        rsp_err    <= 1'b0;
        rr_ptr     <= (int'(grant_id) == NUM_REQ - 1) ?
                      '0 : grant_id + 1'b1;
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      // done beats a same-cycle timeout
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (alu_done) begin
          rsp_result <= alu_result;
        end else if (timed_out) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a stub ALU of programmable latency.
// Vector table, corner sequences, then randomized traffic vs a transaction model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [1:0]  id;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [7:0]  lat;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic [N*3-1:0]  req_opcode;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_result;
  logic            rsp_err;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_opcode;
  logic            alu_start;
  logic [15:0]     alu_result;
  logic            alu_done;

  int n_chk  = 0;
  int n_fail = 0;
  int mul_lat = 3;
  bit stuck   = 1'b0;
  int acnt;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_done   (alu_done)
  );

  function automatic logic [15:0] ref_op(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    if (op[2]) return 16'(a) * 16'(b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // Stub ALU: done one cycle after start, mul_lat cycles for MUL
  always @(posedge clk or posedge rst) begin
    if (rst)            acnt <= 0;
    else if (alu_start) acnt <= alu_opcode[2] ? mul_lat : 1;
    else if (acnt != 0) acnt <= acnt - 1;
  end
  assign alu_done   = (acnt == 1) && !stuck;
  assign alu_result = ref_op(alu_opcode, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[id]        = 1'b1;
    req_a[id*8 +: 8]     = a;
    req_b[id*8 +: 8]     = b;
    req_opcode[id*3 +: 3] = op;
  endtask

  task automatic wait_ready(output logic [N-1:0] g);
    int k = 0;
    @(negedge clk);
    while (req_ready == '0 && k < 300) begin
      @(posedge clk); #1; @(negedge clk); k++;
    end
    g = req_ready;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!rsp_valid && cyc < 300) begin
      @(posedge clk); #1; @(negedge clk); cyc++;
    end
  endtask

  // Single isolated op; grant in cycle T, latency counted from T
  task automatic run_op(input string nm, input int id,
                        input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] res,
                        input logic err, input int lat);
    int t;
    int starts;
    req_valid = '0;
    set_req(id, op, a, b);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_grant"}, 32'(req_ready), 1 << id);
    @(posedge clk); #1;
    req_valid = '0;
    t = 1;
    @(negedge clk);
    chk({nm, "_start1"}, 32'(alu_start), 32'(op != 3'd0));
    if (op != 3'd0) chk({nm, "_opc"}, 32'(alu_opcode), 32'(op));
    starts = alu_start ? 1 : 0;
    while (!rsp_valid && t < 200) begin
      @(posedge clk); #1; @(negedge clk); t++;
      if (alu_start) starts++;
    end
    chk({nm, "_lat"}, t, lat);
    chk({nm, "_nstart"}, starts, (op != 3'd0) ? 1 : 0);
    chk({nm, "_res"}, 32'(rsp_result), 32'(res));
    chk({nm, "_err"}, 32'(rsp_err), 32'(err));
    chk({nm, "_id"}, 32'(rsp_id), id);
    if (op != 3'd0) begin
      chk({nm, "_a"}, 32'(alu_a), 32'(a));
      chk({nm, "_b"}, 32'(alu_b), 32'(b));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t         vt[8];
    logic [N-1:0] gnt;
    logic [N-1:0] exp_rdy;
    int           t;
    int           win;
    int           m_ptr;
    bit           busy;
    exp_t         q[$];
    exp_t         e;
    logic [2:0]   op;

    vt[0] = '{2'd0, OP_ADD, 8'h0F, 8'h01, 16'h0010, 8'd3};
    vt[1] = '{2'd1, OP_AND, 8'hF0, 8'h3C, 16'h0030, 8'd3};
    vt[2] = '{2'd2, OP_NOP, 8'h55, 8'hAA, 16'h0000, 8'd1};
    vt[3] = '{2'd3, OP_XOR, 8'hFF, 8'h0F, 16'h00F0, 8'd3};
    vt[4] = '{2'd0, 3'd4,   8'd200, 8'd100, 16'd20000, 8'd5};
    vt[5] = '{2'd1, OP_ADD, 8'hFF, 8'hFF, 16'h01FE, 8'd3};
    vt[6] = '{2'd2, 3'd7,   8'hFF, 8'hFF, 16'hFE01, 8'd5};
    vt[7] = '{2'd3, 3'd5,   8'h00, 8'h7F, 16'h0000, 8'd5};

    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_res", 32'(rsp_result), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_start", 32'(alu_start), 0);
    chk("rst_a", 32'(alu_a), 0);
    chk("rst_b", 32'(alu_b), 0);
    chk("rst_opc", 32'(alu_opcode), 0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), int'(vt[i].id), vt[i].op,
             vt[i].a, vt[i].b, vt[i].res, 1'b0, int'(vt[i].lat));

    // All requesters pending: grants rotate 0,1,2,3,0
    for (int k = 0; k < N; k++) set_req(k, OP_XOR, 8'hFF, 8'h0F);
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_ready(gnt);
      chk("rr_grant", 32'(gnt), 1 << (g % N));
      @(posedge clk); #1;
      wait_rsp(t);
      chk("rr_valid", 32'(rsp_valid), 1);
      chk("rr_id", 32'(rsp_id), g % N);
      chk("rr_res", 32'(rsp_result), 32'h00F0);
      @(posedge clk); #1;
    end

    // Response backpressure: held stable, no new grant
    for (int k = 0; k < N; k++) set_req(k, 3'd4, 8'd200, 8'd100);
    rsp_ready = 1'b0;
    wait_ready(gnt);
    chk("bp_grant", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    wait_rsp(t);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_res", 32'(rsp_result), 32'd20000);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_a", 32'(alu_a), 32'd200);
      chk("bp_b", 32'(alu_b), 32'd100);
      chk("bp_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'h4);
    chk("bp_next_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(t);
    chk("bp_next_res", 32'(rsp_result), 32'd20000);
    @(posedge clk); #1;

    // Stuck ALU, timeout, and done/timeout tie
    stuck = 1'b1;
    run_op("tmo", 3, OP_ADD, 8'h01, 8'h02, 16'h0000, 1'b1, 66);
    stuck = 1'b0;
    run_op("post_tmo", 0, OP_ADD, 8'h0F, 8'h01, 16'h0010, 1'b0, 3);
    mul_lat = 64;
    run_op("tie", 1, 3'd4, 8'd2, 8'd3, 16'd6, 1'b0, 66);
    mul_lat = 65;
    run_op("late", 2, 3'd6, 8'd2, 8'd3, 16'd0, 1'b1, 66);
    run_op("post_late", 3, OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, 3);

    // Reset during WAIT of a MUL
    mul_lat = 10;
    for (int k = 0; k < N; k++) set_req(k, 3'd4, 8'd12, 8'd13);
    wait_ready(gnt);
    chk("mrst_grant", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(rsp_valid), 0);
    chk("mrst_start", 32'(alu_start), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    chk("mrst_a", 32'(alu_a), 0);
    chk("mrst_opc", 32'(alu_opcode), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_first", 32'(req_ready), 32'h1);
    chk("mrst_norsp", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(t);
    chk("mrst_res", 32'(rsp_result), 32'd156);
    @(posedge clk); #1;

    // Randomized traffic against the transaction model
    rst = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    m_ptr = 0;
    busy  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        set_req(k, 3'($urandom_range(0, 7)), 8'($urandom),
                8'($urandom));
        req_valid[k] = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      mul_lat   = $urandom_range(1, 4);
      @(negedge clk);
      exp_rdy = '0;
      win     = -1;
      if (!busy)
        for (int i = 0; i < N; i++)
          if (win < 0 && req_valid[(m_ptr + i) % N])
            win = (m_ptr + i) % N;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      if (win >= 0) begin
        op    = req_opcode[win*3 +: 3];
        e.id  = 2'(win);
        e.res = ref_op(op, req_a[win*8 +: 8], req_b[win*8 +: 8]);
        e.err = 1'b0;
        q.push_back(e);
        m_ptr = (win + 1) % N;
        busy  = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rnd_pending", 32'(q.size()) , 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_id", 32'(rsp_id), 32'(e.id));
          chk("rnd_res", 32'(rsp_result), 32'(e.res));
          chk("rnd_err", 32'(rsp_err), 32'(e.err));
          busy = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("drain_res", 32'(rsp_result), 32'(e.res));
      end
      @(posedge clk); #1;
    end
    chk("rnd_drain", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
